// File: rtl/piso_bit_serializer_if.sv
// Load handshake and serial output bundle for piso_bit_serializer.
// The producer drives the master side; the serializer is the slave.
interface piso_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             word_done;

  modport master (
    output data_in,
    output load_valid,
    input  load_ready,
    input  ser_out,
    input  ser_valid,
    input  busy,
    input  word_done
  );

  modport slave (
    input  data_in,
    input  load_valid,
    output load_ready,
    output ser_out,
    output ser_valid,
    output busy,
    output word_done
  );
endinterface

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage feeding the serial sequence detector.
// Emits one bit per clock; back-to-back words follow with no gap.
module piso_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  piso_bit_serializer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE  = CW'(WIDTH - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic             out_q, out_d;
  logic             vld_q, vld_d;
  logic             done_q, done_d;
  logic             accept;
  logic             first;
  logic             nxt;
  logic [WIDTH-1:0] shifted;

  assign bus.load_ready = !rst &&
    (state == IDLE || cnt == LAST);
  assign accept = bus.load_valid && bus.load_ready;

  // sreg holds the word aligned so the bit now on ser_out is its head
  assign first   = MSB_FIRST ? bus.data_in[WIDTH-1]
                             : bus.data_in[0];
  assign nxt     = MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
  assign shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                             : {1'b0, sreg[WIDTH-1:1]};

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sreg_d  = sreg;
    out_d   = out_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = '0;
      sreg_d  = bus.data_in;
      out_d   = first;
      vld_d   = 1'b1;
    end else begin
      unique case (state)
        IDLE: ;
        SHIFT: begin
          if (cnt == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            out_d   = IDLE_BIT;
            vld_d   = 1'b0;
          end else begin
            cnt_d  = cnt + 1'b1;
            sreg_d = shifted;
            out_d  = nxt;
            done_d = (cnt == PRE);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      sreg   <= '0;
      out_q  <= IDLE_BIT;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      sreg   <= sreg_d;
      out_q  <= out_d;
      vld_q  <= vld_d;
      done_q <= done_d;
    end
  end

  assign bus.ser_out   = out_q;
  assign bus.ser_valid = vld_q;
  assign bus.busy      = vld_q;
  assign bus.word_done = done_q;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed bench for piso_bit_serializer: MSB-first/idle-0 and
// LSB-first/idle-1 instances sharing clock and reset.
module tb_piso_bit_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  piso_bit_serializer_if #(.WIDTH(8)) m_if ();
  piso_bit_serializer_if #(.WIDTH(8)) l_if ();

  piso_bit_serializer #(
    .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .bus(m_if.slave)
  );

  piso_bit_serializer #(
    .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)
  ) dut_lsb (
    .clk(clk), .rst(rst), .bus(l_if.slave)
  );

  task automatic test_reset();
    rst = 1'b1;
    m_if.load_valid = 1'b0;
    m_if.data_in = '0;
    l_if.load_valid = 1'b0;
    l_if.data_in = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_if.ser_out, m_if.ser_valid, m_if.busy,
         m_if.word_done, m_if.load_ready} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outs got %b want 00000",
        {m_if.ser_out, m_if.ser_valid, m_if.busy,
         m_if.word_done, m_if.load_ready});
    end
    checks++;
    if ({l_if.ser_out, l_if.ser_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_lsb_idle got %b want 10",
        {l_if.ser_out, l_if.ser_valid});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (m_if.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", m_if.load_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] w = 8'hAA;
    m_if.data_in = w;
    m_if.load_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      m_if.load_valid = 1'b0;
      checks++;
      if (i <= 8 && ({m_if.ser_out, m_if.ser_valid,
            m_if.word_done} !== {w[8-i], 1'b1, i == 8})) begin
        errors++;
        $display("FAIL single_c%0d got %b want %b", i,
          {m_if.ser_out, m_if.ser_valid, m_if.word_done},
          {w[8-i], 1'b1, i == 8});
      end
      if (i == 9 && ({m_if.ser_out, m_if.ser_valid,
            m_if.word_done, m_if.load_ready} !== 4'b0001)) begin
        errors++;
        $display("FAIL single_idle got %b want 0001",
          {m_if.ser_out, m_if.ser_valid,
           m_if.word_done, m_if.load_ready});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s = 16'h0AA0;
    m_if.data_in = 8'h0A;
    m_if.load_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 1) m_if.data_in = 8'hA0;
      if (i == 9) m_if.load_valid = 1'b0;
      if (i <= 16) begin
        checks++;
        if ({m_if.ser_out, m_if.ser_valid, m_if.word_done}
            !== {s[16-i], 1'b1, i == 8 || i == 16}) begin
          errors++;
          $display("FAIL b2b_c%0d got %b want %b", i,
            {m_if.ser_out, m_if.ser_valid, m_if.word_done},
            {s[16-i], 1'b1, i == 8 || i == 16});
        end
      end
      if (i == 5 || i == 8) begin
        checks++;
        if (m_if.load_ready !== (i == 8)) begin
          errors++;
          $display("FAIL b2b_ready_c%0d got %b want %b", i,
            m_if.load_ready, i == 8);
        end
      end
    end
    checks++;
    if (m_if.ser_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got %b want 0", m_if.ser_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] s = 16'h3CFF;
    m_if.data_in = 8'h3C;
    m_if.load_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 1) m_if.load_valid = 1'b0;
      if (i == 3) begin
        m_if.data_in = 8'hFF;
        m_if.load_valid = 1'b1;
        #1;
        checks++;
        if (m_if.load_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_ready_c3 got %b want 0",
            m_if.load_ready);
        end
      end
      if (i == 9) m_if.load_valid = 1'b0;
      if (i <= 16) begin
        checks++;
        if ({m_if.ser_out, m_if.ser_valid, m_if.word_done}
            !== {s[16-i], 1'b1, i == 8 || i == 16}) begin
          errors++;
          $display("FAIL bp_c%0d got %b want %b", i,
            {m_if.ser_out, m_if.ser_valid, m_if.word_done},
            {s[16-i], 1'b1, i == 8 || i == 16});
        end
      end
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp = 8'b1010_0000;
    l_if.data_in = 8'h05;
    l_if.load_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      l_if.load_valid = 1'b0;
      checks++;
      if (i <= 8 && ({l_if.ser_out, l_if.ser_valid,
            l_if.word_done} !== {exp[8-i], 1'b1, i == 8})) begin
        errors++;
        $display("FAIL lsb_c%0d got %b want %b", i,
          {l_if.ser_out, l_if.ser_valid, l_if.word_done},
          {exp[8-i], 1'b1, i == 8});
      end
      if (i == 9 && ({l_if.ser_out, l_if.ser_valid}
            !== 2'b10)) begin
        errors++;
        $display("FAIL lsb_idle got %b want 10",
          {l_if.ser_out, l_if.ser_valid});
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w = 8'h81;
    m_if.data_in = 8'hFF;
    m_if.load_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      m_if.load_valid = 1'b0;
      if (i == 4) rst = 1'b1;
      if (i == 5) rst = 1'b0;
      if (i >= 5) begin
        checks++;
        if ({m_if.ser_out, m_if.ser_valid, m_if.word_done}
            !== 3'b000) begin
          errors++;
          $display("FAIL rstmid_c%0d got %b want 000", i,
            {m_if.ser_out, m_if.ser_valid, m_if.word_done});
        end
      end
    end
    m_if.data_in = w;
    m_if.load_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      m_if.load_valid = 1'b0;
      checks++;
      if ({m_if.ser_out, m_if.ser_valid, m_if.word_done}
          !== {w[8-i], 1'b1, i == 8}) begin
        errors++;
        $display("FAIL rstmid_new_c%0d got %b want %b", i,
          {m_if.ser_out, m_if.ser_valid, m_if.word_done},
          {w[8-i], 1'b1, i == 8});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_with_valid();
    rst = 1'b1;
    m_if.data_in = 8'hC3;
    m_if.load_valid = 1'b1;
    #1;
    checks++;
    if (m_if.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstvld_ready got %b want 0", m_if.load_ready);
    end
    @(negedge clk);
    checks++;
    if (m_if.ser_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstvld_noacc got %b want 0", m_if.ser_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    m_if.load_valid = 1'b0;
    checks++;
    if ({m_if.ser_out, m_if.ser_valid} !== 2'b11) begin
      errors++;
      $display("FAIL rstvld_first got %b want 11",
        {m_if.ser_out, m_if.ser_valid});
    end
    @(negedge clk);
    checks++;
    if ({m_if.ser_out, m_if.ser_valid} !== 2'b11) begin
      errors++;
      $display("FAIL rstvld_second got %b want 11",
        {m_if.ser_out, m_if.ser_valid});
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    m_if.data_in = '0;
    m_if.load_valid = 1'b0;
    l_if.data_in = '0;
    l_if.load_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_lsb_first();
    test_reset_mid_word();
    test_reset_with_valid();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the serial sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock on ser_out, which drives the detector's serial input.
- Supports back-to-back words with no idle gap, so patterns spanning a word boundary stay contiguous (needed for overlapping detection).

Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = shift data_in[WIDTH-1] first; 0 = shift data_in[0] first.
- IDLE_BIT, 0, level driven on ser_out when no word is being shifted.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- data_in  input  WIDTH  parallel word; sampled only on an accepting edge.
- load_valid  input  1  producer has a word on data_in.
- load_ready  output  1  serializer can accept a word this cycle.
- ser_out  output  1  serial bit stream to the detector.
- ser_valid  output  1  ser_out carries a real data bit this cycle.
- busy  output  1  a word is being shifted (equals ser_valid).
- word_done  output  1  single-cycle pulse, high during the last bit of a word.

Behaviour:
- Reset is synchronous, active-high on clk. Reset values: ser_out = IDLE_BIT; ser_valid = 0; busy = 0; word_done = 0; state = IDLE; bit counter = 0.
- load_ready is combinational: 0 while rst = 1; otherwise 1 when state = IDLE, or when state = SHIFT and bit counter = WIDTH-1 (last bit).
- Accept: on a rising edge where load_valid and load_ready are both 1, latch data_in into the shift register.
- State machine:
  - IDLE: on accept go to SHIFT; otherwise stay in IDLE.
  - SHIFT, counter < WIDTH-1: increment the counter and advance one bit.
  - SHIFT, counter = WIDTH-1 with accept: reload, counter = 0, stay in SHIFT.
  - SHIFT, counter = WIDTH-1 without accept: go to IDLE.
- Latency and bit timing:
  - ser_out, ser_valid and word_done are registered.
  - The first bit appears in the cycle immediately after the accepting edge.
  - Each bit is held for exactly one cycle. WIDTH bits occupy WIDTH consecutive cycles.
- Bit order: MSB_FIRST = 1 gives data_in[WIDTH-1] down to data_in[0]; MSB_FIRST = 0 gives data_in[0] up to data_in[WIDTH-1].
- word_done is high only in the cycle carrying the last bit.
- Back-to-back: a word accepted at the edge ending the last bit has its first bit in the next cycle. ser_valid stays 1 with no gap and the counter wraps WIDTH-1 -> 0.
- Idle: ser_out = IDLE_BIT and ser_valid = 0.
  - The downstream detector does not qualify its input with ser_valid, so idle bits are seen as data.
  - Example: a word ending in ...101 followed by idle 0 completes 1010. This is intended behaviour, and the integrator chooses IDLE_BIT accordingly.
- While busy and not on the last bit, load_valid is ignored (load_ready = 0). The producer must hold data_in and load_valid until accepted.
- data_in changes while not accepting have no effect.
- Reset mid-word: the word in flight is abandoned and no further bits are emitted. Outputs return to reset values on the next edge.
- rst and load_valid high on the same edge: reset wins and the word is not accepted.

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1, data_in=8'hAA accepted at edge 0 -> ser_out = 1,0,1,0,1,0,1,0 on cycles 1-8; ser_valid = 1 on cycles 1-8 only; word_done only on cycle 8; detector out pulses on cycles 4, 6, 8.
- Back-to-back: 8'h0A then 8'hA0 with load_valid held -> load_ready high in cycle 8; 16 contiguous bits 0000101010100000; ser_valid never drops; word_done on cycles 8 and 16.
- MSB_FIRST=0, data_in=8'h05 -> ser_out = 1,0,1,0,0,0,0,0; word_done on cycle 8.
- Backpressure: load_valid held from cycle 3 of a word with new data 8'hFF -> not accepted until cycle 8; 8'hFF bits appear on cycles 9-16; first word unaltered.
- Reset mid-word: rst asserted at edge 4 -> from cycle 5, ser_valid = 0, ser_out = IDLE_BIT, word_done never pulses; a new word loaded after rst deasserts serializes from its first bit.
- rst and load_valid both high on one edge -> no bits emitted; load_ready = 0 during rst; first accept happens on the first edge with rst = 0.
